jk_bank_seq: RTL
================

# jk_bank_seq

Command-driven sequencer for a bank of `N` JK flip-flops. It accepts a hold/reset/set/toggle command over a valid/ready handshake and applies it to a masked subset of the bank on `cmd_count+1` consecutive clock cycles. It then pulses `done` and returns to idle. It sits between a host or test controller and the flip-flop bank, and it owns all J/K drive so that no other logic writes the bank.

## Interface
- `N`, default 8: number of JK cells in the bank (1..32).
- `CW`, default 8: width of the repeat count.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `cmd_valid` input, 1 bit: a command is presented.
- `cmd_ready` output, 1 bit: the block can accept a command (high only in IDLE).
- `cmd_op` input, 2 bits: J,K pair. 00 hold, 01 reset, 10 set, 11 toggle.
- `cmd_mask` input, N bits: cells affected; unmasked cells hold.
- `cmd_count` input, CW bits: number of applications minus one.
- `cmd_mode` input, 1 bit: 1 selects ripple-count toggling (see Configuration).
- `q` output, N bits: bank state.
- `qbar` output, N bits: always `~q`.
- `busy` output, 1 bit: high in APPLY and DONE.
- `done` output, 1 bit: one-cycle pulse when a command completes.

## Operation
- **FSM states:** IDLE, APPLY, DONE.
  - IDLE → APPLY on `cmd_valid && cmd_ready`. `op`, `mask`, `count` and `mode` are latched at that edge.
  - APPLY stays in APPLY while `rem != 0`; `rem` decrements each cycle. It goes to DONE on the cycle where `rem == 0`.
  - DONE → IDLE unconditionally.
- **Per APPLY cycle, cell i:**
  - When `mask[i]` = 0, J=K=0.
  - Otherwise J,K = `op`.
  - Each cell updates on the edge ending that cycle.
- **Repeat counter:** `rem` is CW bits, loaded with `cmd_count` on accept.
  - `cmd_count` = 0 gives exactly 1 application.
  - `cmd_count` = 2^CW−1 gives 2^CW applications.
  - No wrap.
- **Degenerate commands:** `cmd_mask` = 0 or `op` = 00 still runs the full sequence. `q` is unchanged, and `done` still pulses.
- **Ignored commands:** `cmd_valid` while `busy` is ignored. No queuing, no error flag.
- **Reset values:** `q`=0, `qbar`=all ones, `cmd_ready`=0 while `rst` is high and 1 after release, `busy`=0, `done`=0, state IDLE, `rem`=0.
- **Reset mid-command:** the command is abandoned immediately, `q` clears, and no `done` is produced.

## Timing
- **Edge numbering:** edge 0 is the accept edge.
- **Updates:** `q` changes after edges 1 .. `cmd_count`+1.
- **Status outputs:**
  - `busy` is high from after edge 0 until after edge `cmd_count`+2.
  - `done` is high in the cycle between edges `cmd_count`+1 and `cmd_count`+2.
  - `cmd_ready` returns high after edge `cmd_count`+2.
- **Command period:** the minimum command period is `cmd_count`+3 cycles.
- **Registered outputs:** `q` and `done` are registered. `qbar`, `busy` and `cmd_ready` are decoded from registers with no input-to-output combinational path.

## Configuration
- **Macro `JK_BANK_SEQ_RIPPLE_EN` defined:**
  - When the latched `mode`=1 and `op`=11, each APPLY cycle toggles cell i only if `mask[i]`=1 and every masked cell below i has `q`=1.
  - The masked cells therefore count up by one per application, wrapping to 0 from all ones.
  - For any other `op`, `mode` has no effect.
- **Macro not defined:** `cmd_mode` is ignored and treated as 0; no ripple logic is generated.

## Structure
- **Package `jk_bank_pkg`:**
  - Op encodings `JK_HOLD`, `JK_RESET`, `JK_SET`, `JK_TOGGLE`.
  - FSM state enum `jk_seq_state_t` (IDLE, APPLY, DONE).
- **Sub-module `jk_cell`:** one JK flip-flop, rising-edge, with async active-high `rst` to 0 and outputs `q`/`qbar`. It is instantiated N times by a generate loop.
- **`jk_bank_seq` itself:** holds the FSM, latches, repeat counter and J/K decode.

## Test plan
- **Reset:** assert `rst` mid-simulation → `q`=0x00, `qbar`=0xFF, `busy`=0, `done`=0; `cmd_ready`=1 one edge after release.
- **Set:** op=10, mask=0x0F, count=0 → `q`=0x0F after edge 1; `done` pulses for exactly one cycle after edge 1; `cmd_ready` high after edge 2.
- **Toggle:** starting from `q`=0x0F, op=11, mask=0xFF, count=2 → `q` = 0xF0, 0x0F, 0xF0 after edges 1..3; `done` is a single pulse.
- **Ignored command:** second `cmd_valid` held during busy (op=01, mask=0xFF) → ignored and not executed. It is accepted only once `cmd_ready` rises, then `q`=0x00.
- **Reset mid-command:** `rst` pulsed during APPLY of a count=10 toggle → `q`=0 immediately, no `done`, next command accepted normally.
- **Ripple (`JK_BANK_SEQ_RIPPLE_EN` defined):** `q`=0, op=11, mode=1, mask=0xFF, count=4 → `q`=0x05 at `done`. With mask=0x03, count=4 → `q`=0x01, showing the wrap of the masked field.

Source files
------------

// File: rtl/jk_bank_pkg.sv
// jk_bank_pkg: shared op encodings and sequencer state type for the JK bank sequencer
package jk_bank_pkg;

   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   typedef enum logic [1:0] {IDLE, APPLY, DONE} jk_seq_state_t;

endpackage

// File: rtl/jk_cell.sv
// jk_cell: single rising-edge JK flip-flop with async active-high reset to 0
module jk_cell (
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qbar
);

   // JK next state: 00 hold, 01 clear, 10 set, 11 toggle
   always_ff @(posedge clk or posedge rst)
      if (rst) q <= 1'b0;
      else     q <= j ? (k ? ~q : 1'b1) : (k ? 1'b0 : q);

   assign qbar = ~q;

endmodule

// File: rtl/jk_bank_seq.sv
// jk_bank_seq: command-driven sequencer for a bank of N JK cells; JK_BANK_SEQ_RIPPLE_EN enables ripple-count toggling
module jk_bank_seq
   import jk_bank_pkg::*;
#(
   parameter int N  = 8,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [N-1:0]  cmd_mask,
   input  logic [CW-1:0] cmd_count,
   input  logic          cmd_mode,
   output logic [N-1:0]  q,
   output logic [N-1:0]  qbar,
   output logic          busy,
   output logic          done
);

   jk_seq_state_t state;
   logic          up;
   logic [1:0]    op_r;
   logic [N-1:0]  mask_r;
   logic [CW-1:0] rem;
   logic [N-1:0]  sel;
   logic [N-1:0]  j;
   logic [N-1:0]  k;

`ifdef JK_BANK_SEQ_RIPPLE_EN
   logic mode_r;
`else
   logic unused_mode;
   assign unused_mode = cmd_mode;
`endif

   // up goes high on the first edge after reset so cmd_ready stays low while rst is held
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state  <= IDLE;
         up     <= 1'b0;
         done   <= 1'b0;
         rem    <= '0;
         op_r   <= JK_HOLD;
         mask_r <= '0;
`ifdef JK_BANK_SEQ_RIPPLE_EN
         mode_r <= 1'b0;
`endif
      end else begin
         up <= 1'b1;
         case (state)
            IDLE: if (cmd_valid && cmd_ready) begin
               state  <= APPLY;
               op_r   <= cmd_op;
               mask_r <= cmd_mask;
               rem    <= cmd_count;
`ifdef JK_BANK_SEQ_RIPPLE_EN
               mode_r <= cmd_mode;
`endif
            end
            APPLY: if (rem == '0) begin
               state <= DONE;
               done  <= 1'b1;
            end else rem <= rem - 1'b1;
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end

`ifdef JK_BANK_SEQ_RIPPLE_EN
   // ripple mode: a masked cell toggles only when every masked cell below it is 1
   always_comb begin
      logic c;
      sel = mask_r;
      c   = 1'b1;
      if (mode_r && op_r == JK_TOGGLE)
         for (int b = 0; b < N; b++) begin
            sel[b] = mask_r[b] & c;
            c      = c & (q[b] | ~mask_r[b]);
         end
   end
`else
   assign sel = mask_r;
`endif

   assign j = (state == APPLY) ? sel & {N{op_r[1]}} : '0;
   assign k = (state == APPLY) ? sel & {N{op_r[0]}} : '0;

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_cell
         jk_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .j    (j[g]),
            .k    (k[g]),
            .q    (q[g]),
            .qbar (qbar[g])
         );
      end
   endgenerate

   assign busy      = (state != IDLE);
   assign cmd_ready = up && (state == IDLE);

endmodule
